// File: rtl/stream_output_layer_pkg.sv
// Shared types and sizing helpers for the streaming output layer.
// Optional argmax classifier is enabled by defining OUTPUT_LAYER_ARGMAX_EN.
package stream_output_layer_pkg;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_FINISH = 2'd1,
    ST_SCAN   = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  // Wide enough that NUM_INPUTS full-scale products can never wrap.
  function automatic int acc_w(input int width, input int n_in);
    return 2 * width + $clog2(n_in + 1);
  endfunction

  function automatic int cfg_aw(input int n_out, input int n_in);
    return (n_out * (n_in + 1) > 1) ? $clog2(n_out * (n_in + 1)) : 1;
  endfunction

  function automatic int cls_w(input int n_out);
    return (n_out > 1) ? $clog2(n_out) : 1;
  endfunction

  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/ol_mac_channel.sv
// One output channel: weight/bias row, full-precision accumulator and the
// bias-add / arithmetic shift / saturate stage feeding its result register.
module ol_mac_channel
  import stream_output_layer_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int WIDTH      = 8,
  parameter int FRAC_BITS  = 3,
  localparam int ACC_W = acc_w(WIDTH, NUM_INPUTS),
  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    w_we_i,
  input  logic [IDX_W-1:0]        w_idx_i,
  input  logic                    b_we_i,
  input  logic [WIDTH-1:0]        wdata_i,
  input  logic                    mac_en_i,
  input  logic [IDX_W-1:0]        sel_i,
  input  logic signed [WIDTH-1:0] act_i,
  input  logic                    clr_i,
  input  logic                    fin_i,
  output logic signed [WIDTH-1:0] value_o,
  output logic                    ovf_o
);

  logic signed [WIDTH-1:0]   w_q [NUM_INPUTS];
  logic signed [WIDTH-1:0]   b_q;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W:0]     sum;
  logic signed [ACC_W:0]     shifted;
  logic signed [63:0]        ext;
  logic signed [63:0]        sat;
  logic                      clamp;

  always_comb begin
    prod  = w_q[sel_i] * act_i;
    acc_d = acc_q;
    if (clr_i)         acc_d = '0;
    else if (mac_en_i) acc_d = acc_q + ACC_W'(prod);
    // Bias is aligned to the product's 2*FRAC_BITS scale before the shift back.
    sum     = (ACC_W+1)'(acc_q) + ((ACC_W+1)'(b_q) <<< FRAC_BITS);
    shifted = sum >>> FRAC_BITS;
    ext     = 64'(shifted);
    sat     = saturate(ext, WIDTH);
    clamp   = (sat != ext);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_INPUTS; i++) w_q[i] <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      value_o <= '0;
      ovf_o   <= 1'b0;
    end else begin
      if (w_we_i) w_q[w_idx_i] <= wdata_i;
      if (b_we_i) b_q <= wdata_i;
      acc_q <= acc_d;
      if (fin_i) begin
        value_o <= sat[WIDTH-1:0];
        ovf_o   <= clamp;
      end
    end
  end

endmodule

// File: rtl/stream_output_layer.sv
// Streaming fully-connected output layer: FSM, input counter, config decode.
// Define OUTPUT_LAYER_ARGMAX_EN to add the SCAN state and CLASS_OUT port.
module stream_output_layer
  import stream_output_layer_pkg::*;
#(
  parameter int NUM_INPUTS  = 4,
  parameter int NUM_OUTPUTS = 2,
  parameter int WIDTH       = 8,
  parameter int FRAC_BITS   = 3,
  localparam int CFG_AW = cfg_aw(NUM_OUTPUTS, NUM_INPUTS),
  localparam int CLS_W  = cls_w(NUM_OUTPUTS)
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic                                CFG_WE,
  input  logic [CFG_AW-1:0]                   CFG_ADDR,
  input  logic [WIDTH-1:0]                    CFG_WDATA,
  output logic                                CFG_ERR,
  output logic                                READY,
  input  logic signed [WIDTH-1:0]             VALUE_IN,
  input  logic                                VALID_IN,
  output logic signed [NUM_OUTPUTS*WIDTH-1:0] VALUES_OUT,
  output logic                                VALID_OUT,
  input  logic                                OUT_READY,
  output logic [NUM_OUTPUTS-1:0]              OVERFLOW
`ifdef OUTPUT_LAYER_ARGMAX_EN
  ,
  output logic [CLS_W-1:0]                    CLASS_OUT
`endif
);

  localparam int IDX_W   = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int N_W     = NUM_OUTPUTS * NUM_INPUTS;
  localparam int N_REGS  = NUM_OUTPUTS * (NUM_INPUTS + 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             err_q;
  logic             accept, cfg_ok, fin, clr;

  assign READY     = (state_q == ST_LOAD);
  assign VALID_OUT = (state_q == ST_HOLD);
  assign CFG_ERR   = err_q;
  assign accept    = READY && VALID_IN;
  // Weights are only writable between inferences, never mid-accumulation.
  assign cfg_ok    = CFG_WE && (state_q == ST_LOAD) && (cnt_q == '0) && (int'(CFG_ADDR) < N_REGS);

  for (genvar o = 0; o < NUM_OUTPUTS; o++) begin : g_ch
    logic             w_we, b_we;
    logic [IDX_W-1:0] w_idx;

    always_comb begin
      w_we  = cfg_ok && (int'(CFG_ADDR) >= o * NUM_INPUTS) && (int'(CFG_ADDR) < (o + 1) * NUM_INPUTS);
      b_we  = cfg_ok && (int'(CFG_ADDR) == N_W + o);
      w_idx = IDX_W'(int'(CFG_ADDR) - o * NUM_INPUTS);
    end

    ol_mac_channel #(
      .NUM_INPUTS (NUM_INPUTS),
      .WIDTH      (WIDTH),
      .FRAC_BITS  (FRAC_BITS)
    ) u_ch (
      .clk_i    (CLK),
      .rst_i    (RST),
      .w_we_i   (w_we),
      .w_idx_i  (w_idx),
      .b_we_i   (b_we),
      .wdata_i  (CFG_WDATA),
      .mac_en_i (accept),
      .sel_i    (cnt_q),
      .act_i    (VALUE_IN),
      .clr_i    (clr),
      .fin_i    (fin),
      .value_o  (VALUES_OUT[o*WIDTH +: WIDTH]),
      .ovf_o    (OVERFLOW[o])
    );
  end

`ifdef OUTPUT_LAYER_ARGMAX_EN
  logic [CLS_W-1:0]        scan_q, cls_q;
  logic signed [WIDTH-1:0] max_q, cur, cur_max;
  logic                    scan_done;

  always_comb begin
    cur       = VALUES_OUT[int'(scan_q)*WIDTH +: WIDTH];
    // First comparison seeds the running max with channel 0.
    cur_max   = (scan_q == CLS_W'(1)) ? VALUES_OUT[WIDTH-1:0] : max_q;
    scan_done = (scan_q == CLS_W'(NUM_OUTPUTS - 1));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      scan_q <= CLS_W'(1);
      cls_q  <= '0;
      max_q  <= '0;
    end else if (state_q == ST_SCAN) begin
      if (cur > cur_max) begin
        max_q <= cur;
        cls_q <= scan_q;
      end else begin
        max_q <= cur_max;
        if (scan_q == CLS_W'(1)) cls_q <= '0;
      end
      scan_q <= scan_q + CLS_W'(1);
    end else begin
      scan_q <= CLS_W'(1);
    end
  end

  assign CLASS_OUT = cls_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fin     = 1'b0;
    clr     = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (accept) begin
          if (cnt_q == IDX_W'(NUM_INPUTS - 1)) begin
            cnt_d   = '0;
            state_d = ST_FINISH;
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
          end
        end
      end
      ST_FINISH: begin
        fin     = 1'b1;
`ifdef OUTPUT_LAYER_ARGMAX_EN
        state_d = (NUM_OUTPUTS > 1) ? ST_SCAN : ST_HOLD;
`else
        state_d = ST_HOLD;
`endif
      end
`ifdef OUTPUT_LAYER_ARGMAX_EN
      ST_SCAN: if (scan_done) state_d = ST_HOLD;
`endif
      ST_HOLD: begin
        if (OUT_READY) begin
          clr     = 1'b1;
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_LOAD;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= CFG_WE && !cfg_ok;
    end
  end

endmodule

// File: tb/tb_stream_output_layer.sv
// Scoreboard bench for stream_output_layer (2 inputs, 2 outputs, Q4.3 data).
module tb_stream_output_layer;
  localparam int NI = 2;
  localparam int NO = 2;
  localparam int W  = 8;
  localparam int FB = 3;
  localparam int AW = 3;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              CFG_WE = 1'b0;
  logic [AW-1:0]     CFG_ADDR = '0;
  logic [W-1:0]      CFG_WDATA = '0;
  logic              CFG_ERR;
  logic              READY;
  logic signed [W-1:0] VALUE_IN = '0;
  logic              VALID_IN = 1'b0;
  logic [NO*W-1:0]   VALUES_OUT;
  logic              VALID_OUT;
  logic              OUT_READY = 1'b1;
  logic [NO-1:0]     OVERFLOW;
`ifdef OUTPUT_LAYER_ARGMAX_EN
  logic [0:0]        CLASS_OUT;
`endif

  typedef struct packed {
    logic [NO*W-1:0] vals;
    logic [NO-1:0]   ovf;
    logic [0:0]      cls;
  } exp_t;

  exp_t sb[$];
  int   nchk  = 0;
  int   npass = 0;

  stream_output_layer #(
    .NUM_INPUTS  (NI),
    .NUM_OUTPUTS (NO),
    .WIDTH       (W),
    .FRAC_BITS   (FB)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .CFG_WE     (CFG_WE),
    .CFG_ADDR   (CFG_ADDR),
    .CFG_WDATA  (CFG_WDATA),
    .CFG_ERR    (CFG_ERR),
    .READY      (READY),
    .VALUE_IN   (VALUE_IN),
    .VALID_IN   (VALID_IN),
    .VALUES_OUT (VALUES_OUT),
    .VALID_OUT  (VALID_OUT),
    .OUT_READY  (OUT_READY),
    .OVERFLOW   (OVERFLOW)
`ifdef OUTPUT_LAYER_ARGMAX_EN
    ,
    .CLASS_OUT  (CLASS_OUT)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nchk++;
    if (act === req) npass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  function automatic logic [NO*W-1:0] pack(input int c0, input int c1);
    return {W'(c1), W'(c0)};
  endfunction

  // Monitor: one scoreboard entry per accepted result vector.
  always @(negedge CLK) begin : monitor
    exp_t e;
    if (!RST && VALID_OUT && OUT_READY) begin
      if (sb.size() == 0) begin
        nchk++;
        $display("FAIL unexpected_output: got %0h with empty scoreboard", VALUES_OUT);
      end else begin
        e = sb.pop_front();
        check("values", VALUES_OUT, e.vals);
        check("overflow", OVERFLOW, e.ovf);
`ifdef OUTPUT_LAYER_ARGMAX_EN
        check("class", CLASS_OUT, e.cls);
`endif
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic cfg(input int addr, input int data, input logic exp_err);
    CFG_WE    = 1'b1;
    CFG_ADDR  = AW'(addr);
    CFG_WDATA = W'(data);
    tick();
    CFG_WE = 1'b0;
    check("cfg_err", CFG_ERR, exp_err);
    if (exp_err) begin
      tick();
      check("cfg_err_pulse", CFG_ERR, 0);
    end
  endtask

  task automatic setw(input int w00, input int w01, input int w10, input int w11, input int b0, input int b1);
    cfg(0, w00, 1'b0);
    cfg(1, w01, 1'b0);
    cfg(2, w10, 1'b0);
    cfg(3, w11, 1'b0);
    cfg(4, b0, 1'b0);
    cfg(5, b1, 1'b0);
  endtask

  task automatic send(input int v);
    VALID_IN = 1'b1;
    VALUE_IN = W'(v);
    tick();
    VALID_IN = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!VALID_OUT && n < 30) begin
      tick();
      n++;
    end
    if (!VALID_OUT) begin
      nchk++;
      $display("FAIL valid_timeout: VALID_OUT still 0 after %0d cycles, expected 1", n);
    end
  endtask

  task automatic push(input logic [NO*W-1:0] vals, input logic [NO-1:0] ovf, input logic cls);
    exp_t e;
    e.vals = vals;
    e.ovf  = ovf;
    e.cls  = cls;
    sb.push_back(e);
  endtask

  task automatic infer(input int a, input int b, input logic [NO*W-1:0] vals,
                       input logic [NO-1:0] ovf, input logic cls);
    push(vals, ovf, cls);
    send(a);
    send(b);
    wait_valid();
    tick();
  endtask

  initial begin
    tick();
    tick();
    RST = 1'b0;
    tick();
    check("rst_ready", READY, 1);
    check("rst_valid_out", VALID_OUT, 0);
    check("rst_values", VALUES_OUT, 0);
    check("rst_overflow", OVERFLOW, 0);
    check("rst_cfg_err", CFG_ERR, 0);

    // Basic MAC: ch0 = (64+128)>>3 = 24, ch1 = (128-128)>>3 = 0.
    setw(8, 8, 16, -8, 0, 0);
    infer(8, 16, pack(24, 0), 2'b00, 1'b0);

    // Truncation toward -inf: -1>>>3 = -1, +1>>>3 = 0; argmax picks ch1.
    setw(1, 0, -1, 0, 0, 0);
    infer(-1, 0, pack(-1, 0), 2'b00, 1'b1);

    // Saturation in both directions; ties keep index 0.
    setw(127, 127, 127, 127, 0, 0);
    infer(127, 127, pack(127, 127), 2'b11, 1'b0);
    setw(-128, -128, -128, -128, 0, 0);
    infer(127, 127, pack(-128, -128), 2'b11, 1'b0);

    // Bias only, then all-zero tie.
    setw(0, 0, 0, 0, 0, 8);
    infer(5, -3, pack(0, 8), 2'b00, 1'b1);
    setw(0, 0, 0, 0, 0, 0);
    infer(5, -3, pack(0, 0), 2'b00, 1'b0);

    // Backpressure: result held, READY low, inputs ignored.
    setw(8, 8, 16, -8, 0, 0);
    OUT_READY = 1'b0;
    push(pack(24, 0), 2'b00, 1'b0);
    send(8);
    send(16);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      VALID_IN = 1'b1;
      VALUE_IN = 8'sd100;
      check("hold_values", VALUES_OUT, pack(24, 0));
      check("hold_ready", READY, 0);
      check("hold_valid", VALID_OUT, 1);
      tick();
    end
    VALID_IN  = 1'b0;
    OUT_READY = 1'b1;
    tick();
    check("release_ready", READY, 1);
    check("release_valid", VALID_OUT, 0);
    infer(8, 16, pack(24, 0), 2'b00, 1'b0);

    // Rejected writes: mid-inference and out-of-range address.
    push(pack(24, 0), 2'b00, 1'b0);
    send(8);
    cfg(1, 100, 1'b1);
    send(16);
    wait_valid();
    tick();
    cfg(6, 5, 1'b1);
    infer(8, 16, pack(24, 0), 2'b00, 1'b0);

    // Reset mid-inference with outputs saturated and CFG_ERR high.
    setw(127, 127, 127, 127, 0, 0);
    infer(127, 127, pack(127, 127), 2'b11, 1'b0);
    send(8);
    CFG_WE   = 1'b1;
    CFG_ADDR = AW'(1);
    tick();
    CFG_WE = 1'b0;
    check("pre_rst_cfg_err", CFG_ERR, 1);
    RST = 1'b1;
    #2;
    check("mid_rst_ready", READY, 1);
    check("mid_rst_valid_out", VALID_OUT, 0);
    check("mid_rst_values", VALUES_OUT, 0);
    check("mid_rst_overflow", OVERFLOW, 0);
    check("mid_rst_cfg_err", CFG_ERR, 0);
`ifdef OUTPUT_LAYER_ARGMAX_EN
    check("mid_rst_class", CLASS_OUT, 0);
`endif
    tick();
    RST = 1'b0;
    tick();
    infer(50, 50, pack(0, 0), 2'b00, 1'b0);

    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/stream_output_layer.md
# stream_output_layer

Streaming, fully-connected output layer of the network: accepts one signed fixed-point activation per handshake, accumulates NUM_OUTPUTS weighted sums in parallel, adds per-output bias, saturates to WIDTH and holds the result vector under output backpressure. It replaces the per-neuron serial-configured output stage with a memory-mapped weight/bias register file, full-precision accumulation, saturation, ready/valid output flow control, and an optional argmax classifier.

## Interface
- NUM_INPUTS, 4, activations per inference (>=1)
- NUM_OUTPUTS, 2, output channels (>=1)
- WIDTH, 8, data/weight/bias width, two's complement
- FRAC_BITS, 3, fractional bits of all fixed-point quantities
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- CFG_WE  in  1  config write strobe
- CFG_ADDR  in  CFG_AW=$clog2(NUM_OUTPUTS*(NUM_INPUTS+1))  address; weight[o][i] at o*NUM_INPUTS+i, bias[o] at NUM_OUTPUTS*NUM_INPUTS+o
- CFG_WDATA  in  WIDTH  write data
- CFG_ERR  out  1  one-cycle pulse: write rejected
- READY  out  1  layer accepts VALUE_IN
- VALUE_IN  in  WIDTH signed  activation
- VALID_IN  in  1  VALUE_IN valid
- VALUES_OUT  out  NUM_OUTPUTS*WIDTH signed  results, channel o at [o*WIDTH +: WIDTH]
- VALID_OUT  out  1  result vector valid
- OUT_READY  in  1  downstream accepts result
- OVERFLOW  out  NUM_OUTPUTS  per-channel saturation flag, qualified by VALID_OUT
- CLASS_OUT  out  max(1,$clog2(NUM_OUTPUTS))  argmax index (only with OUTPUT_LAYER_ARGMAX_EN)

## Operation
- States: LOAD, FINISH, SCAN (macro only), HOLD.
- LOAD: READY=1. Accept on VALID_IN&&READY: acc[o] += weight[o][cnt]*VALUE_IN, cnt++. Accepting input cnt==NUM_INPUTS-1 -> FINISH, cnt cleared.
- FINISH (1 cycle): per channel, s = (acc + (bias<<FRAC_BITS)) >>> FRAC_BITS (arithmetic, truncation toward -inf); clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; OVERFLOW[o]=1 if clamped. Register into VALUES_OUT. -> SCAN if macro, else HOLD.
- SCAN: NUM_OUTPUTS-1 cycles, compare channels 1..NUM_OUTPUTS-1 to running max; strict greater-than replaces, so ties keep lowest index. -> HOLD.
- HOLD: VALID_OUT=1; VALUES_OUT, OVERFLOW, CLASS_OUT stable. On OUT_READY=1: VALID_OUT drops, acc cleared, -> LOAD.
- Accumulator width ACC_W = 2*WIDTH+$clog2(NUM_INPUTS+1): no internal wrap for any input set.
- Config: write accepted only in LOAD with cnt==0 and CFG_ADDR in range; otherwise register file unchanged, CFG_ERR=1 the following cycle. Write and first VALUE_IN accepted same cycle: MAC uses old weight; new value visible next cycle.
- VALID_IN outside LOAD ignored, not queued.
- RST: state LOAD, cnt=0, acc=0, all weights/biases 0; READY=1, VALID_OUT=0, VALUES_OUT=0, OVERFLOW=0, CFG_ERR=0, CLASS_OUT=0. Reset mid-inference discards partial sums.

## Timing
- Last input accepted edge t -> VALID_OUT high from edge t+1 (no macro) or t+NUM_OUTPUTS (macro).
- Throughput (no backpressure, no macro): NUM_INPUTS+2 cycles per inference; READY high cycle after OUT_READY accept.
- MAC single-cycle, combinational multiply into accumulator register.
- CFG_ERR registered, exactly one cycle per rejected write.

## Configuration
- OUTPUT_LAYER_ARGMAX_EN defined: SCAN state and CLASS_OUT port present; latency +NUM_OUTPUTS-1 cycles.
- Undefined: no SCAN, no CLASS_OUT port, no comparator logic.

## Structure
- Package stream_output_layer_pkg: state enum, ACC_W and CFG_AW functions, saturate function.
- Sub-module ol_mac_channel: one per output; holds weight/bias row, accumulator, bias-add/shift/saturate; top holds FSM, counter, address decode, argmax.

## Test plan
WIDTH=8, FRAC_BITS=3, NUM_INPUTS=2, NUM_OUTPUTS=2 unless stated.
- weights w0=[8,8], w1=[16,-8], bias 0; inputs 8,16 -> VALUES_OUT ch0=24, ch1=0, OVERFLOW=00, CLASS_OUT=0 (macro).
- all weights 127, inputs 127,127 -> both channels 127, OVERFLOW=11; weights -128, inputs 127,127 -> -128, OVERFLOW=11.
- bias ch1=8, ch0=0, weights 0 -> ch0=0, ch1=8; equal outputs test: all zero -> CLASS_OUT=0.
- hold OUT_READY low 5 cycles after VALID_OUT -> values stable, READY=0, VALID_IN pulses ignored; OUT_READY high -> READY=1 next cycle, next inference correct.
- CFG_WE after first input accepted, and CFG_ADDR=6 -> CFG_ERR pulse each, register file unchanged.
- RST after one accepted input -> all outputs at reset values, weights read back 0 (result of fresh inference = 0).
